// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-control bundle between the ID stage and the stall/flush sequencer.
interface hazard_stall_ctrl_if #(
    parameter int unsigned PERF_W = 16
);
    localparam int unsigned REG_W = 5;

    logic             EXMemRead;
    logic [REG_W-1:0] EXrt;
    logic [REG_W-1:0] IDrs;
    logic [REG_W-1:0] IDrt;
    logic             IDUsesRt;
    logic             IDBranchTaken;
    logic             IDMulDiv;

    logic              PCWrite;
    logic              IFIDWrite;
    logic              IFIDFlush;
    logic              IDEXFlush;
    logic              MDStart;
    logic              MDBusy;
    logic [PERF_W-1:0] StallCycles;

    // Pipeline side: supplies hazard information, consumes control.
    modport master (
        output EXMemRead, EXrt, IDrs, IDrt, IDUsesRt, IDBranchTaken, IDMulDiv,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCycles
    );

    // Sequencer side.
    modport slave (
        input  EXMemRead, EXrt, IDrs, IDrt, IDUsesRt, IDBranchTaken, IDMulDiv,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes and multi-cycle mul/div freezing, plus a stall-cycle counter.
// Control outputs are combinational from state and ID/EX inputs so they act
// in the same cycle the hazard is seen.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned PERF_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  mdcnt;
    logic [CNT_W-1:0]  mdcnt_nx;
    logic [PERF_W-1:0] stall_cnt;
    logic              load_use;
    logic              pc_write;

    // Load in EX writes a register the ID instruction reads; $zero never counts.
    always_comb begin
        load_use = hz.EXMemRead && (hz.EXrt != 5'd0) &&
                   ((hz.EXrt == hz.IDrs) || (hz.IDUsesRt && (hz.EXrt == hz.IDrt)));
    end

    // Control outputs and next state; reset overrides everything.
    always_comb begin
        pc_write     = 1'b1;
        hz.IFIDWrite = 1'b1;
        hz.IFIDFlush = 1'b0;
        hz.IDEXFlush = 1'b0;
        hz.MDStart   = 1'b0;
        hz.MDBusy    = 1'b0;
        state_nx     = state;
        mdcnt_nx     = mdcnt;

        if (Reset) begin
            pc_write     = 1'b0;
            hz.IFIDWrite = 1'b0;
            hz.IFIDFlush = 1'b1;
            hz.IDEXFlush = 1'b1;
            state_nx     = RUN;
            mdcnt_nx     = '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        pc_write     = 1'b0;
                        hz.IFIDWrite = 1'b0;
                        hz.IDEXFlush = 1'b1;
                    end else if (hz.IDMulDiv) begin
                        hz.MDStart = 1'b1;
                        state_nx   = MD_BUSY;
                        mdcnt_nx   = MD_LOAD;
                    end else if (hz.IDBranchTaken) begin
                        hz.IFIDFlush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    // Freeze fetch/decode; held ID instruction is re-evaluated in RUN.
                    hz.MDBusy    = 1'b1;
                    pc_write     = 1'b0;
                    hz.IFIDWrite = 1'b0;
                    hz.IDEXFlush = 1'b1;
                    if (mdcnt == '0) begin
                        state_nx = RUN;
                    end else begin
                        mdcnt_nx = mdcnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = RUN;
                    mdcnt_nx = '0;
                end
            endcase
        end
    end

    // State, countdown and saturating stall counter.
    always_ff @(posedge Clk) begin
        state <= state_nx;
        mdcnt <= mdcnt_nx;
        if (Reset) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign hz.PCWrite     = pc_write;
    assign hz.StallCycles = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: each stimulus step pushes its hand-computed expected
// response; a monitor pops and compares on the falling edge.
module tb_hazard_stall_ctrl;
    typedef struct {
        logic [5:0] ctl;    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy}
        int         stall;  // expected StallCycles, -1 = unknown
    } exp_t;

    localparam logic [5:0] C_RST = 6'b001100;
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_STL = 6'b000100;
    localparam logic [5:0] C_BR  = 6'b111000;
    localparam logic [5:0] C_MDS = 6'b110010;
    localparam logic [5:0] C_BSY = 6'b000101;

    logic Clk;
    logic Reset;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    hazard_stall_ctrl_if #(.PERF_W(16)) hz ();
    hazard_stall_ctrl_if #(.PERF_W(3))  hs ();

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(3)) dut_sat (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hs)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step(input logic r, input logic mr, input logic [4:0] exrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic br, input logic md, input logic [5:0] ctl,
                        input int st);
        exp_t e;
        Reset            = r;
        hz.EXMemRead     = mr;  hs.EXMemRead     = mr;
        hz.EXrt          = exrt; hs.EXrt         = exrt;
        hz.IDrs          = rs;  hs.IDrs          = rs;
        hz.IDrt          = rt;  hs.IDrt          = rt;
        hz.IDUsesRt      = ur;  hs.IDUsesRt      = ur;
        hz.IDBranchTaken = br;  hs.IDBranchTaken = br;
        hz.IDMulDiv      = md;  hs.IDMulDiv      = md;
        e.ctl   = ctl;
        e.stall = st;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t       e;
        logic [5:0] act;
        int         sat;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush,
                       hz.MDStart, hz.MDBusy};
                checks++;
                if (act !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
                end
                if (e.stall >= 0) begin
                    sat = (e.stall > 7) ? 7 : e.stall;
                    checks++;
                    if (hz.StallCycles !== 16'(e.stall)) begin
                        failures++;
                        $display("FAIL stall_cycles t=%0t got=%0d want=%0d",
                                 $time, hz.StallCycles, e.stall);
                    end
                    checks++;
                    if (hs.StallCycles !== 3'(sat)) begin
                        failures++;
                        $display("FAIL stall_sat t=%0t got=%0d want=%0d",
                                 $time, hs.StallCycles, sat);
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        //    R    mr   exrt   rs     rt     ur   br   md    ctl    stall
        step(1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RST, -1);  // 0 reset
        step(1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RST,  0);  // 1 reset
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  0);  // 2 idle
        step(1'b0,1'b1,5'd8, 5'd8, 5'd0, 1'b0,1'b0,1'b0, C_STL,  0);  // 3 LU on rs
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  1);  // 4
        step(1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0, C_RUN,  1);  // 5 $zero
        step(1'b0,1'b1,5'd8, 5'd3, 5'd8, 1'b0,1'b0,1'b0, C_RUN,  1);  // 6 rt unused
        step(1'b0,1'b1,5'd8, 5'd3, 5'd8, 1'b1,1'b0,1'b0, C_STL,  1);  // 7 LU on rt
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0, C_BR,   2);  // 8 branch
        step(1'b0,1'b1,5'd9, 5'd9, 5'd0, 1'b0,1'b1,1'b0, C_STL,  2);  // 9 LU beats branch
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1, C_MDS,  3);  // 10 md, branch ignored
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY,  3);  // 11
        step(1'b0,1'b1,5'd4, 5'd4, 5'd0, 1'b0,1'b1,1'b0, C_BSY,  4);  // 12 hazards ignored
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY,  5);  // 13
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY,  6);  // 14
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  7);  // 15 back in RUN
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MDS,  7);  // 16 first md
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_BSY,  7);  // 17 second held
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_BSY,  8);  // 18
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_BSY,  9);  // 19
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_BSY, 10);  // 20
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MDS, 11);  // 21 second starts
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY, 11);  // 22
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY, 12);  // 23
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY, 13);  // 24
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY, 14);  // 25
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN, 15);  // 26 total 8 more
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MDS, 15);  // 27 md
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_BSY, 15);  // 28 busy #1
        step(1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RST, 16);  // 29 reset on busy #2
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  0);  // 30 aborted, RUN
        step(1'b0,1'b0,5'd8, 5'd8, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  0);  // 31 no load
        step(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RUN,  0);  // 32

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge Clk);
            waited++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
